// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the parametrised register file:
//   - rfState_t      : clear-engine FSM state encoding
//   - DEFAULT_*      : default width / depth / address-width constants
//   - clog2()        : constant-evaluable ceiling log2 helper
// ---------------------------------------------------------------------------
package rf_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rfState_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_DEPTH  = 32;
    localparam int DEFAULT_ADDR_W = int'(clog2(DEFAULT_DEPTH));

endpackage

// File: rtl/rf_clear_ctrl.sv
// ---------------------------------------------------------------------------
// rf_clear_ctrl
// Sequential bulk-clear engine for register_file_param. Walks the array one
// entry per cycle from address 0 to DEPTH-1 and reports writes that had to be
// discarded while the walk was in progress.
// Ports:
//   Clk        in   clock, rising edge
//   Rst        in   asynchronous active-low reset
//   ClrReq     in   start a clear (only honoured in IDLE)
//   RegWrite   in   write enable from the datapath
//   WrIsZero   in   write targets the hardwired-zero register
//   Busy       out  clear in progress
//   WrDropped  out  registered one-cycle pulse: a write was discarded
//   ClrEn      out  clear write enable into the array
//   ClrAddr    out  entry being cleared this cycle
// ---------------------------------------------------------------------------
module rf_clear_ctrl
    import rf_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              ClrReq,
    input  logic              RegWrite,
    input  logic              WrIsZero,
    output logic              Busy,
    output logic              WrDropped,
    output logic              ClrEn,
    output logic [ADDR_W-1:0] ClrAddr
);

    rfState_t          state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= RF_IDLE;
            cnt       <= '0;
            WrDropped <= 1'b0;
        end else begin
            case (state)
                RF_IDLE: begin
                    WrDropped <= 1'b0;
                    if (ClrReq) begin
                        state <= RF_CLEAR;
                    end
                end
                RF_CLEAR: begin
                    // Writes to the zero register are ignored anyway, so
                    // they are not reported as dropped.
                    WrDropped <= RegWrite && !WrIsZero;
                    // DEPTH is a power of two: the counter wraps to 0 on the
                    // final entry by itself.
                    cnt <= cnt + 1'b1;
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= RF_IDLE;
                    end
                end
                default: begin
                    state     <= RF_IDLE;
                    WrDropped <= 1'b0;
                end
            endcase
        end
    end

    assign Busy    = (state == RF_CLEAR);
    assign ClrEn   = (state == RF_CLEAR);
    assign ClrAddr = cnt;

endmodule

// File: rtl/register_file_param.sv
// ---------------------------------------------------------------------------
// register_file_param
// Parametrised multi-read / single-write register file with optional
// hardwired-zero register 0 and a sequential bulk-clear engine.
// Optional feature macro: RF_BYPASS_EN (write-to-read forwarding in IDLE).
// Ports:
//   Clk       in   clock, rising edge
//   Rst       in   asynchronous active-low reset
//   RdAddr    in   NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   RdData    out  NUM_RD packed read data, port k at [k*DATA_W +: DATA_W]
//   RegWrite  in   write enable
//   WrAddr    in   write address
//   WrData    in   write data
//   ClrReq    in   bulk-clear request (sampled only in IDLE)
//   Busy      out  clear in progress
//   WrDropped out  one-cycle pulse when a write is discarded during a clear
// ---------------------------------------------------------------------------
module register_file_param
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
    output logic [NUM_RD*DATA_W-1:0] RdData,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        WrAddr,
    input  logic [DATA_W-1:0]        WrData,
    input  logic                     ClrReq,
    output logic                     Busy,
    output logic                     WrDropped
);

    logic [DATA_W-1:0] regArray [DEPTH];
    logic              clrEn;
    logic [ADDR_W-1:0] clrAddr;
    logic              wrIsZero;

    assign wrIsZero = (ZERO_REG != 0) && (WrAddr == '0);

    rf_clear_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) uClearCtrl (
        .Clk       (Clk),
        .Rst       (Rst),
        .ClrReq    (ClrReq),
        .RegWrite  (RegWrite),
        .WrIsZero  (wrIsZero),
        .Busy      (Busy),
        .WrDropped (WrDropped),
        .ClrEn     (clrEn),
        .ClrAddr   (clrAddr)
    );

    // Clear has priority; datapath writes only land while the engine is idle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regArray[i] <= '0;
            end
        end else if (clrEn) begin
            regArray[clrAddr] <= '0;
        end else if (RegWrite && !wrIsZero) begin
            regArray[WrAddr] <= WrData;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : gRead
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = RdAddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            data = regArray[addr];
`ifdef RF_BYPASS_EN
            if (RegWrite && !clrEn && (WrAddr == addr)) begin
                data = WrData;
            end
`endif
            // Zero register overrides forwarding as well as the array.
            if ((ZERO_REG != 0) && (addr == '0)) begin
                data = '0;
            end
        end

        assign RdData[k*DATA_W +: DATA_W] = data;
    end

endmodule

// File: tb/tb_register_file_param.sv
// ---------------------------------------------------------------------------
// tb_register_file_param
// Directed self-checking bench for register_file_param (default parameters:
// 32 x 32 bits, two read ports, ZERO_REG=1). Inputs change on the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_register_file_param;

    logic        Clk;
    logic        Rst;
    logic [9:0]  RdAddr;
    logic [63:0] RdData;
    logic        RegWrite;
    logic [4:0]  WrAddr;
    logic [31:0] WrData;
    logic        ClrReq;
    logic        Busy;
    logic        WrDropped;

    int nAsserts;
    int nFails;
    int busyCycles;

    register_file_param #(
        .DATA_W   (32),
        .DEPTH    (32),
        .ADDR_W   (5),
        .NUM_RD   (2),
        .ZERO_REG (1)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .RdAddr    (RdAddr),
        .RdData    (RdData),
        .RegWrite  (RegWrite),
        .WrAddr    (WrAddr),
        .WrData    (WrData),
        .ClrReq    (ClrReq),
        .Busy      (Busy),
        .WrDropped (WrDropped)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive both read ports, settle, and compare.
    task automatic readPair(input string tag, input logic [4:0] a0, input logic [4:0] a1,
                            input logic [31:0] e0, input logic [31:0] e1);
        RdAddr = {a1, a0};
        #1;
        check({tag, "_p0"}, RdData[31:0],  e0);
        check({tag, "_p1"}, RdData[63:32], e1);
    endtask

    task automatic writeReg(input logic [4:0] a, input logic [31:0] d);
        @(negedge Clk);
        RegWrite = 1'b1;
        WrAddr   = a;
        WrData   = d;
        @(negedge Clk);
        RegWrite = 1'b0;
    endtask

    initial begin
        nAsserts   = 0;
        nFails     = 0;
        Rst        = 1'b0;
        RdAddr     = '0;
        RegWrite   = 1'b0;
        WrAddr     = '0;
        WrData     = '0;
        ClrReq     = 1'b0;

        // 1. Reset
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        #1;
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_wrdrop", {31'd0, WrDropped}, 32'd0);
        readPair("rst_r0_r8", 5'd0, 5'd8, 32'd0, 32'd0);
        readPair("rst_r31", 5'd31, 5'd31, 32'd0, 32'd0);
        Rst = 1'b1;

        // 2. Write/read: reg i = i*3 for i = 8..25
        for (int i = 8; i <= 25; i++) begin
            writeReg(5'(i), 32'(i * 3));
        end
        for (int i = 8; i <= 24; i += 2) begin
            readPair("wr_pair", 5'(i), 5'(i + 1), 32'(i * 3), 32'(i * 3 + 3));
        end
        writeReg(5'd0, 32'hDEADBEEF);
        #1;
        check("zero_wrdrop", {31'd0, WrDropped}, 32'd0);
        readPair("zero_read", 5'd0, 5'd0, 32'd0, 32'd0);

        // 3. Same-cycle write and read of reg 10
        @(negedge Clk);
        RegWrite = 1'b1;
        WrAddr   = 5'd10;
        WrData   = 32'h1234;
`ifdef RF_BYPASS_EN
        readPair("same_cycle", 5'd10, 5'd10, 32'h1234, 32'h1234);
`else
        readPair("same_cycle", 5'd10, 5'd10, 32'd30, 32'd30);
`endif
        @(negedge Clk);
        RegWrite = 1'b0;
        readPair("next_cycle", 5'd10, 5'd10, 32'h1234, 32'h1234);

        // 4. Fill every register with 0x100+i, then bulk clear
        for (int i = 0; i < 32; i++) begin
            writeReg(5'(i), 32'h100 + 32'(i));
        end
        readPair("fill", 5'd5, 5'd20, 32'h105, 32'h114);
        @(negedge Clk);
        ClrReq     = 1'b1;
        busyCycles = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            if (c == 0) ClrReq = 1'b0;
            #1;
            if (!Busy) break;
            if (c == 10) begin
                // entries 0..9 cleared, 10..31 still stale
                readPair("mid_clear", 5'd5, 5'd20, 32'd0, 32'h114);
            end
            busyCycles++;
        end
        check("clear_len", 32'(busyCycles), 32'd32);
        for (int i = 0; i < 32; i += 2) begin
            readPair("post_clear", 5'(i), 5'(i + 1), 32'd0, 32'd0);
        end

        // 5. Writes and ClrReq during a clear
        @(negedge Clk);
        ClrReq     = 1'b1;
        busyCycles = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clk);
            #1;
            if (!Busy) break;
            case (c)
                0:  ClrReq = 1'b0;
                3:  begin RegWrite = 1'b1; WrAddr = 5'd12; WrData = 32'hAAAA; end
                4:  begin RegWrite = 1'b0; check("drop_pulse", {31'd0, WrDropped}, 32'd1); end
                5:  check("drop_one_cycle", {31'd0, WrDropped}, 32'd0);
                6:  begin RegWrite = 1'b1; WrAddr = 5'd1; WrData = 32'h5555; end
                7:  begin RegWrite = 1'b0; check("drop_pulse2", {31'd0, WrDropped}, 32'd1); end
                8:  begin RegWrite = 1'b1; WrAddr = 5'd0; WrData = 32'h7777; end
                9:  begin RegWrite = 1'b0; check("drop_zero", {31'd0, WrDropped}, 32'd0); end
                10: ClrReq = 1'b1;
                11: ClrReq = 1'b0;
                default: ;
            endcase
            busyCycles++;
        end
        check("clear_len_req", 32'(busyCycles), 32'd32);
        readPair("dropped_wr", 5'd12, 5'd1, 32'd0, 32'd0);
        @(negedge Clk);
        #1;
        check("idle_after", {31'd0, Busy}, 32'd0);

        // 6. Reset in the middle of a clear
        writeReg(5'd3, 32'h33);
        writeReg(5'd20, 32'h2020);
        writeReg(5'd31, 32'h3131);
        readPair("pre_rst", 5'd3, 5'd20, 32'h33, 32'h2020);
        @(negedge Clk);
        ClrReq = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge Clk);
            ClrReq = 1'b0;
        end
        #1;
        check("pre_rst_busy", {31'd0, Busy}, 32'd1);
        Rst = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, Busy}, 32'd0);
        readPair("rst_mid_a", 5'd3, 5'd20, 32'd0, 32'd0);
        readPair("rst_mid_b", 5'd31, 5'd8, 32'd0, 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        writeReg(5'd7, 32'h77);
        #1;
        check("post_rst_busy", {31'd0, Busy}, 32'd0);
        readPair("post_rst_wr", 5'd7, 5'd3, 32'h77, 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        #1;
        readPair("post_rst_hold", 5'd7, 5'd7, 32'h77, 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
Parametrised successor to the team's 32x32 two-read/one-write MIPS register file. Configurable width, depth and read-port count, with an optional hardwired-zero register 0. Adds a sequential bulk-clear engine with a busy handshake. Sits in the decode stage of the datapath, between instruction decode and the ALU operand muxes.

Parameters:
DATA_W, 32, register width in bits.
DEPTH, 32, number of registers; power of two, minimum 4.
ADDR_W, 5, address width; must equal log2(DEPTH).
NUM_RD, 2, number of read ports; 1 to 4.
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes.

Ports:
Clk  in  1  clock; all state updates on the rising edge.
Rst  in  1  reset, asynchronous, active-low.
RdAddr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
RdData  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
RegWrite  in  1  write enable.
WrAddr  in  ADDR_W  write address.
WrData  in  DATA_W  write data.
ClrReq  in  1  bulk-clear request; sampled only in IDLE.
Busy  out  1  high while a clear is in progress.
WrDropped  out  1  one-cycle pulse when a write is discarded because Busy is high.

Behaviour:
- Reset: Rst=0 asynchronously sets all registers to 0, FSM to IDLE, clear counter to 0, Busy=0, WrDropped=0.
- Reset mid-clear: returns to IDLE at once. All registers read 0 after reset.
- Reads are combinational, zero latency: RdData[k] = reg[RdAddr[k]].
- ZERO_REG=1: any address 0 read returns 0. A write to address 0 is silently ignored and does not pulse WrDropped.
- Writes: in IDLE, with RegWrite=1, reg[WrAddr] <= WrData on the rising edge.
- Write/read timing without bypass: a read of the same address in the write cycle returns the old value.
- FSM states: IDLE, CLEAR.
- IDLE to CLEAR: when ClrReq=1 at the edge. In that same edge any IDLE write is still performed, but it is overwritten by the clear.
- CLEAR: each cycle, reg[cnt] <= 0 and cnt increments. Busy=1 throughout CLEAR.
- CLEAR to IDLE: at the edge where cnt=DEPTH-1 is cleared; cnt wraps to 0.
- Clear duration: exactly DEPTH cycles.
- Reads during CLEAR return the current array contents: cleared entries read 0, uncleared entries read their stale value.
- Write during CLEAR: RegWrite=1 discards the write; WrDropped=1 in the following cycle, registered.
- ClrReq during CLEAR: ignored; it is not queued.
- Identical read addresses on several ports: every such port returns the same data.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-to-read forwarding. If RegWrite=1, the FSM is in IDLE, WrAddr==RdAddr[k] and the address is not a zero-reg address, then RdData[k]=WrData in the same cycle.
- Undefined: no forwarding; reads return the array value, i.e. the old data in the write cycle.
- Either way: ZERO_REG precedence holds, and forwarding never applies during CLEAR.

Decomposition:
- Shared package rf_pkg: FSM state encoding (RF_IDLE=1'b0, RF_CLEAR=1'b1), default width/depth constants, and a clog2 helper function.
- Natural sub-module: rf_clear_ctrl, holding the FSM, counter, Busy and WrDropped logic. It drives the clear write enable and clear address into the array.
- Read muxes are a generate loop over NUM_RD inside the top module.

Test Plan:
1. Reset: Rst low for 2 cycles -> Busy=0, WrDropped=0, all ports read 0 at addresses 0, 8 and 31.
2. Write/read: write reg i = i*3 for i=8..25, then read pairs (8,9) … (24,25) -> RdData = 24,27 … 72,75. Read of 0 -> 0 after a write of 0xDEADBEEF to reg 0 (ZERO_REG=1).
3. Same-cycle: write 0x1234 to reg 10 while reading reg 10 -> old value 30 without RF_BYPASS_EN, 0x1234 with it. Next cycle reads 0x1234 in both builds.
4. Clear: fill all registers with nonzero values, then pulse ClrReq -> Busy high for exactly 32 cycles. Mid-clear, reg 5 reads 0 and reg 20 reads its stale value. After the clear, all registers read 0.
5. Write during clear: RegWrite to reg 12 in clear cycle 3 -> WrDropped pulses 1 cycle later; reg 12 reads 0 after the clear. A ClrReq at cycle 10 does not extend Busy.
6. Reset mid-clear: assert Rst at clear cycle 7 -> Busy=0 immediately, all registers 0, FSM in IDLE. A subsequent write works normally.
